// File: rtl/jk_cmd_sequencer.sv
// Queues per-bit JK commands and applies them one at a time to a JK flop bank.
// Define JK_CMD_VERIFY_EN to add a readback VERIFY cycle with sticky err/err_addr.
module jk_cmd_sequencer #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [1:0]        cmd_op,
    output logic [WIDTH-1:0]  j_o,
    output logic [WIDTH-1:0]  k_o,
    input  logic [WIDTH-1:0]  q_i,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StApply, StVerify} state_e;

    state_e state_q, state_d;

    logic [ADDR_W+1:0] fifo_mem [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]     count_q;
    logic              full, empty, push, pop;
    logic [ADDR_W-1:0] head_addr, cur_addr_q;
    logic [1:0]        head_op, cur_op_q;
    logic              addr_ok, done_q;
    logic [WIDTH-1:0]  j_vec, k_vec;

    // Count only reaches DEPTH (a power of two) when full, so its MSB is the full flag.
    assign full      = count_q[PtrW];
    assign empty     = (count_q == '0);
    assign cmd_ready = !full && !rst;
    assign push      = cmd_valid && cmd_ready;
    assign {head_addr, head_op} = fifo_mem[rd_ptr_q];
    assign addr_ok   = (32'(cur_addr_q) < WIDTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= {cmd_addr, cmd_op};
                wr_ptr_q           <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (PtrW + 1)'(1);
            end else if (!push && pop) begin
                count_q <= count_q - (PtrW + 1)'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        j_vec   = '0;
        k_vec   = '0;
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StApply;
                end
            end
            StApply: begin
                if (addr_ok) begin
                    j_vec[cur_addr_q] = cur_op_q[1];
                    k_vec[cur_addr_q] = cur_op_q[0];
                end
`ifdef JK_CMD_VERIFY_EN
                state_d = StVerify;
`else
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StApply;
                end else begin
                    state_d = StIdle;
                end
`endif
            end
`ifdef JK_CMD_VERIFY_EN
            StVerify: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StApply;
                end else begin
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cur_addr_q <= '0;
            cur_op_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == StApply);
            if (pop) begin
                cur_addr_q <= head_addr;
                cur_op_q   <= head_op;
            end
        end
    end

`ifdef JK_CMD_VERIFY_EN
    logic              q_cur, exp_d, exp_q, err_q;
    logic [ADDR_W-1:0] err_addr_q;

    assign q_cur = addr_ok ? q_i[cur_addr_q] : 1'b0;

    always_comb begin
        exp_d = q_cur;
        case (cur_op_q)
            2'b01:   exp_d = 1'b0;
            2'b10:   exp_d = 1'b1;
            2'b11:   exp_d = ~q_cur;
            default: exp_d = q_cur;
        endcase
    end

    // Out-of-range addresses never flag: nothing was driven, so nothing to compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q      <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            if (state_q == StApply) begin
                exp_q <= exp_d;
            end
            if ((state_q == StVerify) && addr_ok && (q_cur != exp_q)) begin
                err_q <= 1'b1;
                if (!err_q) begin
                    err_addr_q <= cur_addr_q;
                end
            end
        end
    end

    assign err      = err_q && !rst;
    assign err_addr = rst ? '0 : err_addr_q;
`else
    logic unused_q;
    assign unused_q = ^q_i;
    assign err      = 1'b0;
    assign err_addr = '0;
`endif

    assign j_o  = rst ? '0 : j_vec;
    assign k_o  = rst ? '0 : k_vec;
    assign done = done_q && !rst;
    assign busy = !rst && ((state_q != StIdle) || !empty);

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer with a behavioural JK flop bank on q_i.
module tb_jk_cmd_sequencer;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DEPTH  = 4;
`ifdef JK_CMD_VERIFY_EN
    localparam int CPC     = 2;
    localparam bit CHECKED = 1'b1;
`else
    localparam int CPC     = 1;
    localparam bit CHECKED = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [1:0]        cmd_op = '0;
    logic [WIDTH-1:0]  j_o, k_o, q_i;
    logic              busy, done, err;
    logic [ADDR_W-1:0] err_addr;

    logic [WIDTH-1:0]  bank_q = '0;
    logic [WIDTH-1:0]  stuck = '0;

    int n_checks = 0;
    int n_fail   = 0;

    jk_cmd_sequencer #(
        .WIDTH (WIDTH),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .cmd_op   (cmd_op),
        .j_o      (j_o),
        .k_o      (k_o),
        .q_i      (q_i),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_addr (err_addr)
    );

    always #5 clk = ~clk;

    assign q_i = bank_q & ~stuck;

    always @(posedge clk) begin
        if (rst) begin
            bank_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({j_o[i], k_o[i]})
                    2'b01:   bank_q[i] <= 1'b0;
                    2'b10:   bank_q[i] <= 1'b1;
                    2'b11:   bank_q[i] <= ~bank_q[i];
                    default: ;
                endcase
            end
        end
    end

    // Event logs sampled mid-cycle.
    int         cyc = 0;
    int         done_n = 0;
    int         apply_n = 0;
    int         full_n = 0;
    int         done_cyc [64];
    logic       done_q0 [64];
    logic [7:0] apply_log [64];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            if (done_n < 64) begin
                done_cyc[done_n] = cyc;
                done_q0[done_n]  = q_i[0];
            end
            done_n++;
        end
        if ((j_o | k_o) != '0) begin
            if (apply_n < 64) apply_log[apply_n] = {j_o, k_o};
            apply_n++;
        end
        if (!cmd_ready && !rst) full_n++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] a, input logic [1:0] o);
        logic acc;
        acc       = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_op    = o;
        for (int t = 0; t < 20; t++) begin
            acc = cmd_ready;
            tick();
            if (acc) break;
        end
        check("push_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle();
        cmd_valid = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (!busy) break;
            tick();
        end
        check("idle_reached", 32'(busy), 32'd0);
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         base_d, base_a, base_f;
        logic [1:0] t3_addr [8];
        logic [1:0] t3_op [8];
        logic [3:0] je, ke;
        logic       seen;

        t3_addr = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2};
        t3_op   = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b11, 2'b10, 2'b11};

        // Reset values
        tick();
        tick();
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_j", 32'(j_o), 32'd0);
        check("rst_k", 32'(k_o), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_addr", 32'(err_addr), 32'd0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", 32'(cmd_ready), 32'd1);

        // Single set on addr 2, cycle by cycle
        base_d    = done_n;
        cmd_valid = 1'b1;
        cmd_addr  = 2'd2;
        cmd_op    = 2'b10;
        tick();
        cmd_valid = 1'b0;
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_pre_j", 32'(j_o), 32'd0);
        tick();
        check("t1_apply_j", 32'(j_o), 32'h4);
        check("t1_apply_k", 32'(k_o), 32'd0);
        check("t1_apply_nodone", 32'(done), 32'd0);
        tick();
        check("t1_done", 32'(done), 32'd1);
        check("t1_j_off", 32'(j_o), 32'd0);
        check("t1_q2", 32'(bank_q[2]), 32'd1);
        tick();
        check("t1_done_end", 32'(done), 32'd0);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_err", 32'(err), 32'd0);
        check("t1_done_cnt", 32'(done_n - base_d), 32'd1);

        // Three back-to-back toggles on addr 0
        base_d = done_n;
        push(2'd0, 2'b11);
        push(2'd0, 2'b11);
        push(2'd0, 2'b11);
        wait_idle();
        check("t2_done_cnt", 32'(done_n - base_d), 32'd3);
        check("t2_space0", 32'(done_cyc[base_d + 1] - done_cyc[base_d]), 32'(CPC));
        check("t2_space1", 32'(done_cyc[base_d + 2] - done_cyc[base_d + 1]), 32'(CPC));
        check("t2_q0_a", 32'(done_q0[base_d]), 32'd1);
        check("t2_q0_b", 32'(done_q0[base_d + 1]), 32'd0);
        check("t2_q0_c", 32'(done_q0[base_d + 2]), 32'd1);

        // Stream of 8 commands with no source stalls; order must be preserved
        base_d = done_n;
        base_a = apply_n;
        base_f = full_n;
        for (int i = 0; i < 8; i++) push(t3_addr[i], t3_op[i]);
        wait_idle();
        check("t3_done_cnt", 32'(done_n - base_d), 32'd8);
        check("t3_apply_cnt", 32'(apply_n - base_a), 32'd8);
        for (int i = 0; i < 8; i++) begin
            je = '0;
            ke = '0;
            je[t3_addr[i]] = t3_op[i][1];
            ke[t3_addr[i]] = t3_op[i][0];
            check("t3_order", 32'(apply_log[base_a + i]), 32'({je, ke}));
        end
        check("t3_ready_dropped", 32'(full_n != base_f), 32'(CHECKED));
        check("t3_err", 32'(err), 32'd0);

        // Readback mismatch: q_i[1] stuck low, then q_i[3] too
        stuck = 4'b0010;
        push(2'd1, 2'b10);
        wait_idle();
        check("t4_err", 32'(err), 32'(CHECKED));
        check("t4_err_addr", 32'(err_addr), CHECKED ? 32'd1 : 32'd0);
        stuck = 4'b1010;
        push(2'd3, 2'b10);
        wait_idle();
        check("t4_err_sticky", 32'(err), 32'(CHECKED));
        check("t4_err_addr_kept", 32'(err_addr), CHECKED ? 32'd1 : 32'd0);
        stuck = '0;

        // Reset during an APPLY cycle with commands queued
        for (int i = 0; i < 7; i++) push(2'(i % 4), (i % 2 == 0) ? 2'b10 : 2'b11);
        cmd_valid = 1'b0;
        seen      = 1'b0;
        for (int t = 0; t < 10; t++) begin
            if ((j_o | k_o) != '0) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("t5_apply_seen", 32'(seen), 32'd1);
        rst    = 1'b1;
        base_d = done_n;
        tick();
        check("t5_j", 32'(j_o), 32'd0);
        check("t5_k", 32'(k_o), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (10) tick();
        check("t5_no_done", 32'(done_n - base_d), 32'd0);
        check("t5_busy_after", 32'(busy), 32'd0);
        check("t5_bank", 32'(bank_q), 32'd0);
        check("t5_err_cleared", 32'(err), 32'd0);

        // Set, hold, reset on addr 3
        base_d = done_n;
        push(2'd3, 2'b10);
        wait_idle();
        check("t6_set", 32'(bank_q[3]), 32'd1);
        push(2'd3, 2'b00);
        wait_idle();
        check("t6_hold", 32'(bank_q[3]), 32'd1);
        push(2'd3, 2'b01);
        wait_idle();
        check("t6_reset", 32'(bank_q[3]), 32'd0);
        check("t6_done_cnt", 32'(done_n - base_d), 32'd3);
        check("t6_err", 32'(err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
